// File: rtl/fpnew_pkg.sv
// fpnew_pkg: FPU request field enums, status flags and reorder-slot type for the issue ROB.
package fpnew_pkg;
  typedef enum logic [2:0] {RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, DYN = 3'b111} roundmode_e;
  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;
  typedef enum logic [2:0] {FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4} fp_format_e;
  typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
  typedef struct packed {
    logic    alloc;
    logic    done;
    status_t status;
  } rob_slot_t;
  function automatic status_t status_or(status_t a, status_t b);
    return a | b;
  endfunction
endpackage

// File: rtl/fpnew_issue_rob.sv
// fpnew_issue_rob: tags FP requests, issues them to the FPU and writes results back in issue order.
module fpnew_issue_rob
  import fpnew_pkg::*;
#(
  parameter int unsigned Width = 64,
  parameter int unsigned NumEntries = 4,
  parameter int unsigned RegAddrWidth = 5,
  localparam int unsigned TagWidth = $clog2(NumEntries)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [2:0][Width-1:0]   req_operands_i,
  input  roundmode_e              req_rnd_mode_i,
  input  operation_e              req_op_i,
  input  logic                    req_op_mod_i,
  input  fp_format_e              req_src_fmt_i,
  input  fp_format_e              req_dst_fmt_i,
  input  int_format_e             req_int_fmt_i,
  input  logic                    req_vectorial_op_i,
  input  logic [RegAddrWidth-1:0] req_rd_i,
  output logic [2:0][Width-1:0]   fpu_operands_o,
  output roundmode_e              fpu_rnd_mode_o,
  output operation_e              fpu_op_o,
  output logic                    fpu_op_mod_o,
  output fp_format_e              fpu_src_fmt_o,
  output fp_format_e              fpu_dst_fmt_o,
  output int_format_e             fpu_int_fmt_o,
  output logic                    fpu_vectorial_op_o,
  output logic [TagWidth-1:0]     fpu_tag_o,
  output logic                    fpu_in_valid_o,
  input  logic                    fpu_in_ready_i,
  output logic                    fpu_flush_o,
  input  logic [Width-1:0]        fpu_result_i,
  input  status_t                 fpu_status_i,
  input  logic [TagWidth-1:0]     fpu_tag_i,
  input  logic                    fpu_out_valid_i,
  output logic                    fpu_out_ready_o,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [Width-1:0]        wb_result_o,
  output status_t                 wb_status_o,
  output logic [RegAddrWidth-1:0] wb_rd_o,
  output status_t                 fflags_o,
  input  logic                    fflags_clr_i,
  output logic                    spurious_o,
  output logic                    busy_o
);
  rob_slot_t               r_slot [NumEntries];
  logic [RegAddrWidth-1:0] r_rd   [NumEntries];
  logic [Width-1:0]        r_res  [NumEntries];
  logic [TagWidth-1:0]     r_head, r_tail;
  logic [TagWidth:0]       r_count;
  status_t                 r_fflags;
  logic                    r_spur;
  logic                    w_full, w_issue, w_write, w_retire;
  assign w_full             = r_count == (TagWidth+1)'(NumEntries);
  assign fpu_in_valid_o     = req_valid_i & ~w_full & ~flush_i;
  assign req_ready_o        = fpu_in_ready_i & ~w_full & ~flush_i;
  assign w_issue            = fpu_in_valid_o & fpu_in_ready_i;
  assign fpu_tag_o          = r_tail;
  assign fpu_operands_o     = req_operands_i;
  assign fpu_rnd_mode_o     = req_rnd_mode_i;
  assign fpu_op_o           = req_op_i;
  assign fpu_op_mod_o       = req_op_mod_i;
  assign fpu_src_fmt_o      = req_src_fmt_i;
  assign fpu_dst_fmt_o      = req_dst_fmt_i;
  assign fpu_int_fmt_o      = req_int_fmt_i;
  assign fpu_vectorial_op_o = req_vectorial_op_i;
  assign fpu_flush_o        = flush_i;
  // Every in-flight op already owns a slot, so results can always be accepted.
  assign fpu_out_ready_o    = 1'b1;
  assign w_write            = fpu_out_valid_i & r_slot[fpu_tag_i].alloc & ~flush_i;
  assign wb_valid_o         = r_slot[r_head].alloc & r_slot[r_head].done;
  assign wb_result_o        = r_res[r_head];
  assign wb_status_o        = r_slot[r_head].status;
  assign wb_rd_o            = r_rd[r_head];
  assign w_retire           = wb_valid_o & wb_ready_i & ~flush_i;
  assign fflags_o           = r_fflags;
  assign spurious_o         = r_spur;
  assign busy_o             = r_count != '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumEntries; i++) r_slot[i] <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_fflags <= '0;
      r_spur   <= 1'b0;
    end else begin
      r_spur   <= fpu_out_valid_i & ~r_slot[fpu_tag_i].alloc;
      r_fflags <= fflags_clr_i ? (w_retire ? r_slot[r_head].status : '0)
                               : (w_retire ? status_or(r_fflags, r_slot[r_head].status) : r_fflags);
      if (flush_i) begin
        for (int i = 0; i < NumEntries; i++) r_slot[i] <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_issue) begin
          r_slot[r_tail] <= '{alloc: 1'b1, done: 1'b0, status: '0};
          r_rd[r_tail]   <= req_rd_i;
          r_tail         <= r_tail + 1'b1;
        end
        if (w_write) begin
          r_slot[fpu_tag_i].done   <= 1'b1;
          r_slot[fpu_tag_i].status <= fpu_status_i;
          r_res[fpu_tag_i]         <= fpu_result_i;
        end
        if (w_retire) begin
          r_slot[r_head] <= '0;
          r_head         <= r_head + 1'b1;
        end
        r_count <= (w_issue & ~w_retire) ? r_count + 1'b1 :
                   (w_retire & ~w_issue) ? r_count - 1'b1 : r_count;
      end
    end
  end
endmodule

// File: doc/fpnew_issue_rob.md
# fpnew_issue_rob

Initiator-side companion to the FPU top: accepts FP requests from the core, assigns each an in-flight tag, issues it to the FPU over valid/ready, and collects the tagged results. The FPU's output arbiter returns results out of order across operation groups, so results are re-ordered into issue order before writeback. Sits between the core's FP issue stage and the FPU top.

## Interface
- `Width`, 64: FP operand/result width; equals the FPU `WIDTH`.
- `NumEntries`, 4: reorder slots, power of two ≥2; bounds in-flight ops.
- `RegAddrWidth`, 5: destination register index width.
- `TagWidth`, localparam `$clog2(NumEntries)`.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: kill all in-flight ops.
- `req_valid_i` in 1; `req_ready_o` out 1: upstream handshake.
- `req_operands_i` in 3×Width; `req_rnd_mode_i`, `req_op_i`, `req_op_mod_i`, `req_src_fmt_i`, `req_dst_fmt_i`, `req_int_fmt_i`, `req_vectorial_op_i` in (fpnew_pkg types): request fields.
- `req_rd_i` in RegAddrWidth: destination register.
- `fpu_operands_o` … `fpu_vectorial_op_o` out: request fields, passed through unchanged.
- `fpu_tag_o` out TagWidth: allocated slot index.
- `fpu_in_valid_o` out 1; `fpu_in_ready_i` in 1: FPU input handshake.
- `fpu_flush_o` out 1: equals `flush_i`.
- `fpu_result_i` in Width; `fpu_status_i` in status_t; `fpu_tag_i` in TagWidth; `fpu_out_valid_i` in 1; `fpu_out_ready_o` out 1: FPU output handshake.
- `wb_valid_o` out 1; `wb_ready_i` in 1; `wb_result_o` out Width; `wb_status_o` out status_t; `wb_rd_o` out RegAddrWidth: in-order writeback.
- `fflags_o` out status_t; `fflags_clr_i` in 1: sticky accrued exceptions.
- `spurious_o` out 1: one-cycle pulse on result with tag of a non-allocated slot.
- `busy_o` out 1: any slot allocated.

## Operation
- Slot state: `alloc`, `done`, `rd`, `result`, `status`. Pointers `head`, `tail` (TagWidth, natural wrap), `count` (TagWidth+1 bits, 0..NumEntries).
- Issue: `fpu_in_valid_o = req_valid_i & ~full & ~flush_i`; `req_ready_o = fpu_in_ready_i & ~full & ~flush_i`; `fpu_tag_o = tail`. On fire: slot[tail] alloc=1, done=0, rd latched; tail+1.
- `fpu_in_ready_i` may depend combinationally on `fpu_in_valid_o`; no path from `fpu_in_ready_i` to `fpu_in_valid_o`.
- Collect: `fpu_out_ready_o = 1` (space pre-reserved). On valid with slot[tag].alloc: store result/status, done=1. Non-allocated tag: data dropped, `spurious_o`=1 next cycle.
- Retire: `wb_valid_o = slot[head].alloc & slot[head].done`; outputs muxed from slot[head]. On fire: slot cleared, head+1, `fflags_o |= status`.
- `fflags_clr_i` with a same-cycle retire: result = retiring status only.
- count: +1 on issue, −1 on retire; both → unchanged. Full (count==NumEntries) with same-cycle retire: no issue that cycle; ready depends only on registered count.
- Flush: all alloc/done cleared, head=tail=count=0 next cycle; concurrent issue blocked, result and retire ignored. `fflags_o` retained.
- Reset: all slots cleared, pointers/count 0, `fflags_o`=0, `spurious_o`=0; flushes even mid-operation.

## Timing
- Issue path combinational (zero added latency).
- Result write → `wb_valid_o` at earliest next cycle; no bypass.
- Back-to-back retire, one per cycle.
- Reset values: `wb_valid_o`=0, `busy_o`=0, `fflags_o`=0, `spurious_o`=0, `fpu_out_ready_o`=1, `fpu_flush_o`=`flush_i`.
- `wb_*` data stable while `wb_valid_o & ~wb_ready_i`.

## Structure
- Slot struct type and status OR helper go in fpnew_pkg; request field types reuse existing fpnew_pkg enums.
- Single flat module; no sub-module (slot array + pointer logic is small).

## Test plan
- Single op, tag 0, result after 3 cycles with status NX → `wb_valid_o` the cycle after; `wb_rd_o`=req rd; `fflags_o`=NX after retire.
- Issue tags 0,1,2; results return 2,0,1 → writeback strictly in order 0,1,2, one per cycle with `wb_ready_i`=1.
- Fill 4 slots, hold `wb_ready_i`=0 → `req_ready_o`=0; retire one → exactly one new issue, tag wraps to 0.
- `flush_i` with 3 in flight, late result for tag 1 → dropped with `spurious_o` pulse; `busy_o`=0; next issue tag 0.
- Result tag 3 with only 0 allocated → `spurious_o` pulse, state unchanged.
- Assert `rst_i` with 2 in flight and `fflags_o`≠0 → all outputs at reset values next cycle.
